hilo_muldiv: RTL

- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits beside and downstream of the ALU in EX. Decode issues MULT/MULTU/DIV/DIVU to this unit instead of the ALU 64-bit path.
- MFHI/MFLO read the results. MTHI/MTLO write HI/LO directly.
- Provides a busy/stall handshake so the pipeline holds HI/LO readers until a result lands.

---
 rtl/hilo_muldiv_pkg.sv | 29 ++
 rtl/hilo_muldiv_step.sv | 29 ++
 rtl/hilo_muldiv.sv | 129 ++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings and sizing for the HI/LO multiply/divide unit.
package hilo_muldiv_pkg;

    localparam int unsigned MDU_XLEN  = 32;
    localparam int unsigned MDU_CNT_W = $clog2(MDU_XLEN);

    typedef enum logic [1:0] {
        MDU_OP_MULT  = 2'd0,
        MDU_OP_MULTU = 2'd1,
        MDU_OP_DIV   = 2'd2,
        MDU_OP_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_e;

    function automatic logic mdu_is_signed(input mdu_op_e o);
        return (o == MDU_OP_MULT) || (o == MDU_OP_DIV);
    endfunction

    function automatic logic mdu_is_div(input mdu_op_e o);
        return (o == MDU_OP_DIV) || (o == MDU_OP_DIVU);
    endfunction

endpackage

// File: rtl/hilo_muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module hilo_muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic              is_div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] diff;

    // Multiply keeps {partial, multiplier}; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        rem_sh = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
        diff   = rem_sh[XLEN-1:0] - opnd_i;
        if (!is_div_i) begin
            acc_o = {sum, acc_i[XLEN-1:1]};
        end else if (rem_sh >= {1'b0, opnd_i}) begin
            acc_o = {diff, acc_i[XLEN-2:0], 1'b1};
        end else begin
            acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = MDU_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    mdu_state_e        state_q;
    mdu_op_e           op_q;
    logic [XLEN-1:0]   a_q, b_q, opnd_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_res_q, neg_rem_q, divz_q;
    logic              busy_q, done_q;
    logic [XLEN-1:0]   hi_q, lo_q;

    logic              is_div, signed_op;
    logic [XLEN-1:0]   a_mag, b_mag, quo, rem;
    logic [2*XLEN-1:0] prod, step_acc;
    logic [XLEN-1:0]   hi_d, lo_d;

    hilo_muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div_i (is_div),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_acc)
    );

    always_comb begin
        is_div    = mdu_is_div(op_q);
        signed_op = mdu_is_signed(op_q);
        a_mag     = (signed_op && a_q[XLEN-1]) ? -a_q : a_q;
        b_mag     = (signed_op && b_q[XLEN-1]) ? -b_q : b_q;
        prod      = neg_res_q ? -acc_q : acc_q;
        quo       = acc_q[XLEN-1:0];
        rem       = acc_q[2*XLEN-1:XLEN];
        hi_d      = prod[2*XLEN-1:XLEN];
        lo_d      = prod[XLEN-1:0];
        // Divide by zero bypasses the sign fixup: quotient all ones, HI gets the raw dividend.
        if (is_div) begin
            if (divz_q) begin
                hi_d = a_q;
                lo_d = '1;
            end else begin
                hi_d = neg_rem_q ? -rem : rem;
                lo_d = neg_res_q ? -quo : quo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= MDU_OP_MULT;
            a_q       <= '0;
            b_q       <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q    <= mdu_op_e'(op);
                        a_q     <= a;
                        b_q     <= b;
                        busy_q  <= 1'b1;
                        state_q <= ST_PREP;
                    end else begin
                        if (mthi) hi_q <= wdata;
                        if (mtlo) lo_q <= wdata;
                    end
                end
                ST_PREP: begin
                    neg_res_q <= signed_op & (a_q[XLEN-1] ^ b_q[XLEN-1]);
                    neg_rem_q <= signed_op & a_q[XLEN-1];
                    divz_q    <= (b_q == '0);
                    acc_q     <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                    opnd_q    <= is_div ? b_mag : a_mag;
                    cnt_q     <= CNT_W'(XLEN - 1);
                    state_q   <= ST_RUN;
                end
                ST_RUN: begin
                    acc_q <= step_acc;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) state_q <= ST_FIX;
                end
                ST_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
